mmio_input_ctrl: RTL and testbench

Memory-mapped input peripheral on the MIO bus. It is the CPU-facing read side, complementing the seg7 output path. It synchronizes and debounces the board switches and buttons, latches rising-edge events into a sticky pending register, and raises an interrupt request. The CPU reads levels and events through a 4-word register window and clears events with write-1-to-clear.

---
 rtl/mmio_in_pkg.sv | 29 ++
 rtl/in_debounce.sv | 52 +++++
 rtl/mmio_input_ctrl.sv | 132 +++++++++++++
 tb/tb_mmio_input_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_in_pkg.sv
// Shared constants for the MIO input peripheral: register word offsets,
// PENDING/IRQ_EN bit layout and the bus address width.
// Optional build macro: MMIO_IN_FALLEDGE_EN adds the FALL_PENDING register.
package mmio_in_pkg;

  // Register word offsets (byte address bits above [1:0])
  localparam int OFF_SW_LEVEL     = 0;
  localparam int OFF_BTN_LEVEL    = 1;
  localparam int OFF_PENDING      = 2;
  localparam int OFF_IRQ_EN       = 3;
  localparam int OFF_FALL_PENDING = 4;

`ifdef MMIO_IN_FALLEDGE_EN
  localparam int ADDR_W = 3;
`else
  localparam int ADDR_W = 2;
`endif

  // Event-vector layout: switches occupy the low bits, buttons sit above them
  localparam int DEF_SW_W = 16;
  localparam int SW_BASE  = 0;

  function automatic int btn_base(input int sw_w);
    return SW_BASE + sw_w;
  endfunction

  localparam int BTN_BASE = btn_base(DEF_SW_W);

endpackage

// File: rtl/in_debounce.sv
// One input bit: 2-FF synchronizer, debounce counter and accepted stable level.
// chg pulses for one cycle right after level takes a new value, so the
// direction of the change is simply the current level.
module in_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DB_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      level <= 1'b0;
      chg   <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        chg   <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_input_ctrl.sv
// MIO-bus input peripheral: debounced switches/buttons, sticky rising-edge
// PENDING (W1C, set wins), IRQ_EN mask and a registered interrupt request.
// Optional build macro: MMIO_IN_FALLEDGE_EN adds FALL_PENDING at offset 4
// (3-bit addr) which captures falling edges and also feeds irq.
module mmio_input_ctrl
  import mmio_in_pkg::*;
#(
  parameter int SW_W      = 16,
  parameter int BTN_W     = 5,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [SW_W-1:0]   sw_i,
  input  logic [BTN_W-1:0]  btn_i,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  localparam int EV_W    = SW_W + BTN_W;
  localparam int BTN_LSB = btn_base(SW_W);

  logic [EV_W-1:0] raw_vec;
  logic [EV_W-1:0] level_vec;
  logic [EV_W-1:0] chg_vec;
  logic [EV_W-1:0] rise_vec;
  logic [EV_W-1:0] pending;
  logic [EV_W-1:0] irq_en;
  logic [EV_W-1:0] irq_src;
  logic            wr_pending;
  logic            wr_irq_en;
  logic            unused_wdata;

  assign raw_vec[SW_BASE +: SW_W]  = sw_i;
  assign raw_vec[BTN_LSB +: BTN_W] = btn_i;

  // Upper data bits have no register behind them
  assign unused_wdata = ^wdata[31:EV_W];

  for (genvar g = 0; g < EV_W; g++) begin : g_db
    in_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk   (clk),
      .rstn  (rstn),
      .raw   (raw_vec[g]),
      .level (level_vec[g]),
      .chg   (chg_vec[g])
    );
  end

  assign rise_vec   = chg_vec & level_vec;
  assign wr_pending = sel & we & (addr == ADDR_W'(OFF_PENDING));
  assign wr_irq_en  = sel & we & (addr == ADDR_W'(OFF_IRQ_EN));

  // Sticky rising-edge flags; a new edge beats a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else if (wr_pending) begin
      pending <= (pending & ~wdata[EV_W-1:0]) | rise_vec;
    end else begin
      pending <= pending | rise_vec;
    end
  end

  // Interrupt enable mask
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_en <= '0;
    end else if (wr_irq_en) begin
      irq_en <= wdata[EV_W-1:0];
    end
  end

`ifdef MMIO_IN_FALLEDGE_EN
  logic [EV_W-1:0] fall_vec;
  logic [EV_W-1:0] fall_pending;
  logic            wr_fall_pending;

  assign fall_vec        = chg_vec & ~level_vec;
  assign wr_fall_pending = sel & we & (addr == ADDR_W'(OFF_FALL_PENDING));

  // Sticky falling-edge flags, same W1C/set-wins rule as PENDING
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fall_pending <= '0;
    end else if (wr_fall_pending) begin
      fall_pending <= (fall_pending & ~wdata[EV_W-1:0]) | fall_vec;
    end else begin
      fall_pending <= fall_pending | fall_vec;
    end
  end

  assign irq_src = (pending | fall_pending) & irq_en;
`else
  assign irq_src = pending & irq_en;
`endif

  // Registered interrupt request, one cycle behind the flag/mask registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else begin
      irq <= |irq_src;
    end
  end

  // Side-effect-free read mux, zero when not selected
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        ADDR_W'(OFF_SW_LEVEL):     rdata[SW_W-1:0]  = level_vec[SW_BASE +: SW_W];
        ADDR_W'(OFF_BTN_LEVEL):    rdata[BTN_W-1:0] = level_vec[BTN_LSB +: BTN_W];
        ADDR_W'(OFF_PENDING):      rdata[EV_W-1:0]  = pending;
        ADDR_W'(OFF_IRQ_EN):       rdata[EV_W-1:0]  = irq_en;
`ifdef MMIO_IN_FALLEDGE_EN
        ADDR_W'(OFF_FALL_PENDING): rdata[EV_W-1:0]  = fall_pending;
`endif
        default:                   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_input_ctrl.sv
// Bench for mmio_input_ctrl with DB_CYCLES=4: directed timing steps followed
// by a randomized phase compared every cycle against a behavioural model.
module tb_mmio_input_ctrl;

  localparam int SW_W  = 16;
  localparam int BTN_W = 5;
  localparam int EV    = SW_W + BTN_W;
  localparam int DB    = 4;
`ifdef MMIO_IN_FALLEDGE_EN
  localparam int AW = 3;
`else
  localparam int AW = 2;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [SW_W-1:0]   sw_i = '0;
  logic [BTN_W-1:0]  btn_i = '0;
  logic              sel = 1'b0;
  logic              we = 1'b0;
  logic [AW-1:0]     addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              irq;

  int checks = 0;
  int errors = 0;

  mmio_input_ctrl #(
    .SW_W      (SW_W),
    .BTN_W     (BTN_W),
    .DB_CYCLES (DB),
    .CNT_W     (3)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .sw_i  (sw_i),
    .btn_i (btn_i),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A level is accepted once the raw samples taken 2..DB+1 edges ago all
  // disagree with the current accepted level (2 sync stages + DB cycles).
  logic [EV-1:0] smp [1:DB+1];
  logic [EV-1:0] stable_m, pend_m, en_m, rise_p, fpend_m, fall_p, nxt_m, clr_m;
  logic          irq_m;

  function automatic logic window_differs(input int b);
    for (int j = 2; j <= DB + 1; j++)
      if (smp[j][b] == stable_m[b]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 1; j <= DB + 1; j++) smp[j] = '0;
      stable_m = '0; pend_m = '0; en_m = '0; rise_p = '0;
      fpend_m = '0; fall_p = '0; irq_m = 1'b0;
    end else begin
      nxt_m = stable_m;
      for (int b = 0; b < EV; b++)
        if (window_differs(b)) nxt_m[b] = ~stable_m[b];
`ifdef MMIO_IN_FALLEDGE_EN
      irq_m = |((pend_m | fpend_m) & en_m);
`else
      irq_m = |(pend_m & en_m);
`endif
      clr_m  = (sel && we && addr == AW'(2)) ? wdata[EV-1:0] : '0;
      pend_m = (pend_m & ~clr_m) | rise_p;
      clr_m  = (sel && we && addr == AW'(4)) ? wdata[EV-1:0] : '0;
      fpend_m = (fpend_m & ~clr_m) | fall_p;
      if (sel && we && addr == AW'(3)) en_m = wdata[EV-1:0];
      rise_p   = nxt_m & ~stable_m;
      fall_p   = ~nxt_m & stable_m;
      stable_m = nxt_m;
      for (int j = DB + 1; j >= 2; j--) smp[j] = smp[j-1];
      smp[1] = {btn_i, sw_i};
    end
  end

  function automatic logic [31:0] model_rd(input int a);
    case (a)
      0: return 32'(stable_m[SW_W-1:0]);
      1: return 32'(stable_m[EV-1:SW_W]);
      2: return 32'(pend_m);
      3: return 32'(en_m);
`ifdef MMIO_IN_FALLEDGE_EN
      4: return 32'(fpend_m);
`endif
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- helpers (called at a negedge) ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input int a, output logic [31:0] v);
    sel = 1'b1; we = 1'b0; addr = AW'(a);
    #1;
    v = rdata;
    sel = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = AW'(a); wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  // ---------------- directed steps + random phase ----------------
  initial begin
    logic [31:0] v;
    int idx;
    int op;

    // 1. reset
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      peek(a, v);
      chk("reset_rdata", v, 32'h0);
    end
    chk("reset_irq", 32'(irq), 32'h0);

    // 2. bounce on sw[3], last toggle to 1 accepted 6 cycles later
    for (int i = 0; i < 10; i++) begin
      sw_i[3] = ~sw_i[3];
      repeat (2) begin
        @(negedge clk);
        peek(0, v);
        chk("bounce_early", 32'(v[3]), 32'h0);
      end
    end
    sw_i[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      peek(0, v);
      chk("bounce_lvl", 32'(v[3]), 32'(k >= 6));
      peek(2, v);
      chk("bounce_pend", 32'(v[3]), 32'(k >= 7));
    end

    // 3. button event raises irq, W1C drops it
    wr(2, 32'h8);
    wr(3, 32'h10000);
    btn_i[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      peek(2, v);
      chk("irq_pend", v, (k >= 7) ? 32'h10000 : 32'h0);
      chk("irq_line", 32'(irq), 32'(k >= 8));
    end
    repeat (2) @(negedge clk);
    btn_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    wr(2, 32'h10000);
    peek(2, v);
    chk("w1c_pend", v, 32'h0);
    chk("w1c_irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    chk("w1c_irq", 32'(irq), 32'h0);

    // 4. clear lands on the same edge as a new rising edge of sw[5]
    sw_i[5] = 1'b1;
    repeat (6) @(negedge clk);
    wr(2, 32'h20);
    peek(2, v);
    chk("set_wins", v, 32'h20);

    // 5. read-only level registers, unselected reads
    wr(0, 32'hFFFF);
    peek(0, v);
    chk("ro_sw", v, 32'h28);
    wr(1, 32'h1F);
    peek(1, v);
    chk("ro_btn", v, 32'h0);
    sel = 1'b0; addr = AW'(2);
    #1;
    chk("unsel_rdata", rdata, 32'h0);
    peek(2, v);
    chk("pend_nonzero", v, 32'h20);

    // 6. reset in the middle of a debounce count
    wr(2, 32'h1FFFFF);
    sw_i[0] = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    peek(0, v);
    chk("rst_mid_lvl", v, 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      peek(0, v);
      chk("rst_rel_lvl", v, (k >= 6) ? 32'h29 : 32'h0);
      peek(2, v);
      chk("rst_rel_pend", v, (k >= 7) ? 32'h29 : 32'h0);
    end

    // 7. randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, SW_W - 1);
        sw_i[idx] = ~sw_i[idx];
      end
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, BTN_W - 1);
        btn_i[idx] = ~btn_i[idx];
      end
      op    = $urandom_range(0, 3);
      sel   = (op != 3);
      we    = (op == 0);
      addr  = AW'($urandom_range(0, 3));
      wdata = $urandom;
      #1;
      chk("rand_rdata", rdata, sel ? model_rd(int'(addr)) : 32'h0);
      chk("rand_irq", 32'(irq), 32'(irq_m));
    end
    @(negedge clk);
    sel = 1'b0; we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
